// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encodings, slot numbering and default beat width for the TDM link
package tdm_pkg;
    localparam int TDM_WIDTH = 1;
    typedef enum logic {ST_HUNT = 1'b0, ST_RUN = 1'b1} state_t;
    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: framed beat input and decoded channel outputs of the 4-slot demultiplexer
interface tdm_demux4_if #(parameter int WIDTH = tdm_pkg::TDM_WIDTH);
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] a, b, c, d;
    logic [1:0]       sel;
    logic             frame_valid;
    logic             frame_err;
    logic             locked;
    modport master (output din_valid, sync, din,
                    input a, b, c, d, sel, frame_valid, frame_err, locked);
    modport slave (input din_valid, sync, din,
                   output a, b, c, d, sel, frame_valid, frame_err, locked);
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit next-expected-slot counter with clear, jump-to-slot-1 and increment
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load1,
    input  logic       inc,
    output logic [1:0] sel,
    output logic       last
);
    // clear wins over a frame-start load, which wins over a plain advance; slot 3 wraps to 0
    always_ff @(posedge clk)
        if (reset || clear) sel <= SLOT_A;
        else if (load1) sel <= SLOT_B;
        else if (inc) sel <= sel + 2'd1;

    assign last = sel == SLOT_D;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: steers framed slot beats into channels a..d and publishes whole frames atomically
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH
) (
    input logic         clk,
    input logic         reset,
    tdm_demux4_if.slave bus
);
    state_t           st, nxt;
    logic [1:0]       sel, wr_idx;
    logic             last, clr, ld1, inc, wr, fv, fe;
    logic [WIDTH-1:0] shadow [3];
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic             fv_q, fe_q;

    tdm_slot_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .load1 (ld1),
        .inc   (inc),
        .sel   (sel),
        .last  (last)
    );

    // frame lock FSM: a sync beat always restarts at slot 0; a missing sync at slot 0 drops lock
    always_comb begin
        nxt    = st;
        clr    = 1'b0;
        ld1    = 1'b0;
        inc    = 1'b0;
        wr     = 1'b0;
        wr_idx = SLOT_A;
        fv     = 1'b0;
        fe     = 1'b0;
        if (bus.din_valid) begin
            if (st == ST_HUNT) begin
                if (bus.sync) begin
                    wr  = 1'b1;
                    ld1 = 1'b1;
                    nxt = ST_RUN;
                end
            end else if (bus.sync) begin
                wr  = 1'b1;
                ld1 = 1'b1;
                fe  = sel != SLOT_A;
            end else if (sel == SLOT_A) begin
                fe  = 1'b1;
                clr = 1'b1;
                nxt = ST_HUNT;
            end else begin
                wr     = !last;
                wr_idx = sel;
                inc    = 1'b1;
                fv     = last;
            end
        end
    end

    // state, shadow slots and published outputs; the slot-3 beat goes straight to d
    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= ST_HUNT;
            shadow <= '{default: '0};
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            fv_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            st   <= nxt;
            fv_q <= fv;
            fe_q <= fe;
            for (int i = 0; i < 3; i++)
                if (wr && wr_idx == 2'(i)) shadow[i] <= bus.din;
            if (fv) {a_q, b_q, c_q, d_q} <= {shadow[0], shadow[1], shadow[2], bus.din};
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.c           = c_q;
    assign bus.d           = d_q;
    assign bus.sel         = sel;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.locked      = st == ST_RUN;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for the 4-slot demultiplexer against a slot-list reference model
module tb_tdm_demux4;
    typedef struct {
        logic [1:0]  sel;
        logic        locked, fv, fe;
        logic [31:0] outs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    exp_t        sq[$];
    logic [31:0] fq[$];
    logic [7:0]  part[$];
    bit          m_locked = 1'b0;
    logic [31:0] m_out = '0;

    tdm_demux4_if #(.WIDTH(8)) bus ();
    tdm_demux4 #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // one cycle of stimulus; the model decides the response from the list of slots collected so far
    task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] dat);
        exp_t e;
        @(negedge clk);
        #1;
        reset         = rst;
        bus.din_valid = v;
        bus.sync      = s;
        bus.din       = dat;
        e.fv = 1'b0;
        e.fe = 1'b0;
        if (rst) begin
            part.delete();
            m_locked = 1'b0;
            m_out    = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    part.delete();
                    part.push_back(dat);
                    m_locked = 1'b1;
                end
            end else if (s) begin
                e.fe = part.size() != 0;
                part.delete();
                part.push_back(dat);
            end else if (part.size() == 0) begin
                e.fe = 1'b1;
                m_locked = 1'b0;
            end else begin
                part.push_back(dat);
                if (part.size() == 4) begin
                    m_out = {part[0], part[1], part[2], part[3]};
                    fq.push_back(m_out);
                    e.fv = 1'b1;
                    part.delete();
                end
            end
        end
        e.sel    = 2'(part.size());
        e.locked = m_locked;
        e.outs   = m_out;
        sq.push_back(e);
    endtask

    task automatic frame(input logic [7:0] w0, w1, w2, w3);
        step(0, 1, 1, w0);
        step(0, 1, 0, w1);
        step(0, 1, 0, w2);
        step(0, 1, 0, w3);
    endtask

    // monitor: per-cycle status check, plus a frame pop whenever the DUT publishes one
    always @(negedge clk) begin
        exp_t e;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("sel", 32'(bus.sel), 32'(e.sel));
            chk("locked", 32'(bus.locked), 32'(e.locked));
            chk("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
            chk("frame_err", 32'(bus.frame_err), 32'(e.fe));
            chk("abcd", {bus.a, bus.b, bus.c, bus.d}, e.outs);
            chk("fv_fe_exclusive", 32'(bus.frame_valid & bus.frame_err), 32'd0);
        end
        if (bus.frame_valid) begin
            if (fq.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL frame: got unexpected frame_valid with %0h", {bus.a, bus.b, bus.c, bus.d});
            end else chk("frame", {bus.a, bus.b, bus.c, bus.d}, fq.pop_front());
        end
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.din       = '0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        frame(8'h01, 8'h00, 8'h01, 8'h01);
        step(1, 0, 0, 0);
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h00);
        frame(8'h01, 8'h00, 8'h00, 8'h01);
        frame(8'h01, 8'h01, 8'h01, 8'h01);
        step(0, 1, 1, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h55);
        step(0, 0, 0, 0);
        frame(8'h11, 8'h22, 8'h33, 8'h44);
        step(0, 1, 1, 8'hA0);
        step(0, 1, 0, 8'hB0);
        repeat (3) step(0, 0, 0, 8'hEE);
        step(0, 1, 0, 8'hC0);
        step(0, 1, 0, 8'hD0);
        step(0, 1, 1, 8'h5A);
        step(0, 1, 0, 8'h6B);
        step(1, 1, 0, 8'h7C);
        step(0, 1, 0, 8'h01);
        frame(8'h12, 8'h34, 8'h56, 8'h78);
        for (int i = 0; i < 600; i++) begin
            bit s;
            s = (part.size() == 0) ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
            step($urandom_range(99) == 0, $urandom_range(3) != 0, s, 8'($urandom));
        end
        repeat (3) step(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("status_queue_drained", 32'(sq.size()), 32'd0);
        chk("frame_queue_drained", 32'(fq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
